// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type, PC step, bench NOP and a counter-width helper for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: FIFO of {pc, instr}; ports: push/pop/flush, write data, head data, count, full, empty
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BUF_DEPTH   = 2,
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int CW = cnt_w(BUF_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [CW-1:0]          o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  logic [INSTR_WIDTH-1:0] r_instr [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_pc    [BUF_DEPTH];
  logic [PW-1:0]          r_rd, r_wr;
  logic [CW-1:0]          r_count;
  logic                   w_push, w_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = r_count == CW'(BUF_DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_instr = r_instr[r_rd];
  assign o_pc    = r_pc[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr] <= i_instr;
        r_pc[r_wr]    <= i_pc;
        r_wr          <= inc(r_wr);
      end
      if (w_pop) r_rd <= inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + one-outstanding imem request FSM feeding a small buffer to decode; ports: clk/rst_n, imem req/rsp, decode out, redirect in
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    BUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc
);
  localparam int CW = cnt_w(BUF_DEPTH);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc, r_addr;
  logic                  r_req_valid, r_drop_pend;
  logic [CW-1:0]         w_count;
  logic                  w_full, w_empty, w_push, w_pop, w_space;
  logic [ADDR_WIDTH-1:0] w_redir_pc, w_next_pc;

  assign w_redir_pc     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_next_pc      = redirect_valid ? w_redir_pc : r_pc;
  assign w_push         = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop          = instr_valid && instr_ready;
  // room for one more request once this cycle's push/pop have landed
  assign w_space        = (w_count + CW'(w_push) - CW'(w_pop)) < CW'(BUF_DEPTH);
  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_addr;
  assign instr_valid    = !w_empty;

  fetch_buffer #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redirect_valid),
    .i_instr(imem_rsp_data),
    .i_pc   (r_addr),
    .o_instr(instruction),
    .o_pc   (instr_pc),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req_valid <= 1'b0;
      r_drop_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (redirect_valid || !w_full || w_pop) begin
          r_state     <= REQ;
          r_req_valid <= 1'b1;
          r_addr      <= w_next_pc;
        end
        // a redirect seen while stalled here marks the eventual response for dropping
        REQ: if (imem_req_ready) begin
          r_req_valid <= 1'b0;
          r_drop_pend <= 1'b0;
          r_state     <= (redirect_valid || r_drop_pend) ? DROP : WAIT;
          if (!r_drop_pend) r_pc <= r_addr + ADDR_WIDTH'(PC_STEP);
        end else if (redirect_valid) r_drop_pend <= 1'b1;
        WAIT: if (imem_rsp_valid) begin
          r_state     <= (redirect_valid || w_space) ? REQ : IDLE;
          r_req_valid <= redirect_valid || w_space;
          r_addr      <= w_next_pc;
        end else if (redirect_valid) r_state <= DROP;
        DROP: if (imem_rsp_valid) begin
          r_state     <= REQ;
          r_req_valid <= 1'b1;
          r_addr      <= w_next_pc;
        end
        default: r_state <= IDLE;
      endcase
      if (redirect_valid) r_pc <= w_redir_pc;
    end
  end
endmodule
